// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the instruction fetch path:
//               fetch FSM state encoding, PC defaults and the NOP word.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Fetch FSM states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  localparam int unsigned C_PC_STEP   = 4;
  localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] C_NOP_WORD  = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc
// Description : Fetch program counter. A load (branch/jump) takes priority
//               over an increment and is forced to word alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc
  import cpu_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(C_RESET_PC),
  parameter int unsigned          PC_STEP  = C_PC_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  input  logic [ADDR_W-1:0] inc_base,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] r_pc;

  // PC register: redirect load wins; increment is relative to the delivered address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (load) begin
      r_pc <= {load_pc[ADDR_W-1:2], 2'b00};
    end else if (inc) begin
      r_pc <= inc_base + ADDR_W'(PC_STEP);
    end
  end

  assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit. Issues req/ack reads to instruction
//               memory, delivers each good word to the IR with a one-cycle
//               IRWre strobe, and drops responses made stale by a redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(C_RESET_PC),
  parameter int unsigned          PC_STEP  = C_PC_STEP
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              FetchReq,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [31:0]       MemData,
  output logic [31:0]       InstrData,
  output logic              IRWre,
  output logic [ADDR_W-1:0] PCOut,
  output logic              FetchDone,
  output logic              Busy
);

  fetch_state_t      r_state, w_next_state;
  logic              r_mem_req, w_mem_req;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [31:0]       r_instr, w_instr;
  logic [ADDR_W-1:0] r_pcout, w_pcout;
  logic              r_irwre, w_irwre;
  logic              w_pc_load, w_pc_inc;
  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_redirect_aligned;

  assign w_redirect_aligned = {RedirectPC[ADDR_W-1:2], 2'b00};

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_fetch_pc (
    .clk      (clk),
    .rst_n    (Reset),
    .load     (w_pc_load),
    .load_pc  (RedirectPC),
    .inc      (w_pc_inc),
    .inc_base (r_mem_addr),
    .pc       (w_pc)
  );

  // Next-state and next-output logic; a redirect always retargets the PC
  always_comb begin
    w_next_state = r_state;
    w_mem_req    = r_mem_req;
    w_mem_addr   = r_mem_addr;
    w_instr      = r_instr;
    w_pcout      = r_pcout;
    w_irwre      = 1'b0;
    w_pc_load    = 1'b0;
    w_pc_inc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pc_load = Redirect;
        if (FetchReq) begin
          w_mem_req    = 1'b1;
          w_mem_addr   = Redirect ? w_redirect_aligned : w_pc;
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (MemAck && !Redirect) begin
          w_instr      = MemData;
          w_pcout      = r_mem_addr;
          w_pc_inc     = 1'b1;
          w_irwre      = 1'b1;
          w_mem_req    = 1'b0;
          w_next_state = ST_IDLE;
        end else if (Redirect && MemAck) begin
          // Old request retired this cycle: reissue straight at the target
          w_pc_load    = 1'b1;
          w_mem_addr   = w_redirect_aligned;
        end else if (Redirect) begin
          // Request cannot be withdrawn: let it finish, then discard it
          w_pc_load    = 1'b1;
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_pc_load = Redirect;
        if (MemAck) begin
          // Stale data dropped; the owed fetch goes to the latest target
          w_mem_addr   = Redirect ? w_redirect_aligned : w_pc;
          w_next_state = ST_WAIT;
        end
      end
      default: begin
        w_mem_req    = 1'b0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered memory request and IR-side outputs
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_instr    <= C_NOP_WORD;
      r_pcout    <= RESET_PC;
      r_irwre    <= 1'b0;
    end else begin
      r_mem_req  <= w_mem_req;
      r_mem_addr <= w_mem_addr;
      r_instr    <= w_instr;
      r_pcout    <= w_pcout;
      r_irwre    <= w_irwre;
    end
  end

  assign MemReq    = r_mem_req;
  assign MemAddr   = r_mem_addr;
  assign InstrData = r_instr;
  assign PCOut     = r_pcout;
  assign IRWre     = r_irwre;
  assign FetchDone = r_irwre;
  assign Busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. Directed stimulus pushes
//               expected {InstrData, PCOut} pairs; a monitor pops them on
//               every IRWre strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk;
  logic        Reset;
  logic        FetchReq;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemData;
  logic [31:0] InstrData;
  logic        IRWre;
  logic [31:0] PCOut;
  logic        FetchDone;
  logic        Busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb[$];

  instr_fetch #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .FetchReq   (FetchReq),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .MemReq     (MemReq),
    .MemAddr    (MemAddr),
    .MemAck     (MemAck),
    .MemData    (MemData),
    .InstrData  (InstrData),
    .IRWre      (IRWre),
    .PCOut      (PCOut),
    .FetchDone  (FetchDone),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue FetchReq from IDLE for one cycle; afterwards the request is visible
  task automatic start_fetch(input string name, input logic [31:0] exp_addr);
    FetchReq = 1'b1;
    tick();
    FetchReq = 1'b0;
    check({name, "_memreq"}, {31'd0, MemReq}, 32'd1);
    check({name, "_memaddr"}, MemAddr, exp_addr);
  endtask

  // Ack the outstanding request and expect it to be delivered
  task automatic ack_deliver(input logic [31:0] data, input logic [31:0] pc);
    MemAck  = 1'b1;
    MemData = data;
    sb.push_back({data, pc});
    tick();
    MemAck = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest expected delivery
  always @(negedge clk) begin
    if (Reset && (IRWre || FetchDone)) begin
      logic [63:0] e;
      n_checks++;
      if (IRWre !== FetchDone) begin
        n_errors++;
        $display("FAIL strobe_pair: IRWre %b FetchDone %b", IRWre, FetchDone);
      end else if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_irwre: got InstrData %h PCOut %h, expected no strobe", InstrData, PCOut);
      end else begin
        e = sb.pop_front();
        if (InstrData !== e[63:32] || PCOut !== e[31:0]) begin
          n_errors++;
          $display("FAIL deliver: got %h@%h expected %h@%h", InstrData, PCOut, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; Reset = 1'b0; FetchReq = 1'b0; Redirect = 1'b0;
    RedirectPC = 32'd0; MemAck = 1'b0; MemData = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_memreq", {31'd0, MemReq}, 32'd0);
    check("rst_irwre", {31'd0, IRWre}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_memaddr", MemAddr, 32'd0);
    check("rst_instr", InstrData, 32'd0);
    check("rst_pcout", PCOut, 32'd0);
    Reset = 1'b1;

    // Zero-wait fetch with ack held high from cycle 0
    FetchReq = 1'b1; MemAck = 1'b1; MemData = 32'h2001_0005;
    sb.push_back({32'h2001_0005, 32'h0});
    tick();
    FetchReq = 1'b0;
    check("s1_memreq", {31'd0, MemReq}, 32'd1);
    check("s1_memaddr", MemAddr, 32'd0);
    check("s1_irwre_c1", {31'd0, IRWre}, 32'd0);
    tick();
    MemAck = 1'b0;
    check("s1_irwre_c2", {31'd0, IRWre}, 32'd1);
    check("s1_instr", InstrData, 32'h2001_0005);

    // Ack delayed 3 cycles; a FetchReq while busy is ignored
    start_fetch("s2", 32'h4);
    for (int i = 0; i < 3; i++) begin
      FetchReq = (i == 1);
      tick();
      check("s2_hold_req", {31'd0, MemReq}, 32'd1);
      check("s2_hold_addr", MemAddr, 32'h4);
      check("s2_busy", {31'd0, Busy}, 32'd1);
    end
    FetchReq = 1'b0;
    ack_deliver(32'hA5A5_0004, 32'h4);
    check("s2_idle_busy", {31'd0, Busy}, 32'd0);
    check("s2_idle_req", {31'd0, MemReq}, 32'd0);
    tick();
    check("s2_no_extra_req", {31'd0, MemReq}, 32'd0);
    check("s2_irwre_pulse", {31'd0, IRWre}, 32'd0);

    // Redirect while waiting at 8; stale DEADBEEF must be dropped
    start_fetch("s3", 32'h8);
    Redirect = 1'b1; RedirectPC = 32'h0000_0040;
    tick();
    Redirect = 1'b0;
    check("s3_drain_addr", MemAddr, 32'h8);
    check("s3_drain_req", {31'd0, MemReq}, 32'd1);
    tick();
    MemAck = 1'b1; MemData = 32'hDEAD_BEEF;
    tick();
    MemAck = 1'b0;
    check("s3_no_irwre", {31'd0, IRWre}, 32'd0);
    check("s3_instr_held", InstrData, 32'hA5A5_0004);
    check("s3_new_addr", MemAddr, 32'h40);
    check("s3_new_req", {31'd0, MemReq}, 32'd1);
    ack_deliver(32'h1111_0040, 32'h40);

    // Redirect + FetchReq together in IDLE, unaligned target
    Redirect = 1'b1; RedirectPC = 32'h0000_0103; FetchReq = 1'b1;
    tick();
    Redirect = 1'b0; FetchReq = 1'b0;
    check("s4_memaddr", MemAddr, 32'h100);
    check("s4_memreq", {31'd0, MemReq}, 32'd1);
    // Redirect coincident with ack: response dropped, reissue at target
    Redirect = 1'b1; RedirectPC = 32'h0000_0200; MemAck = 1'b1; MemData = 32'hBAD0_0100;
    tick();
    Redirect = 1'b0; MemAck = 1'b0;
    check("s4_same_cycle_addr", MemAddr, 32'h200);
    check("s4_same_cycle_req", {31'd0, MemReq}, 32'd1);
    ack_deliver(32'h2222_0200, 32'h200);
    start_fetch("s4_next", 32'h204);
    ack_deliver(32'h3333_0204, 32'h204);

    // PC wrap from the top of the address space
    Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
    tick();
    Redirect = 1'b0;
    check("s5_idle_redirect_busy", {31'd0, Busy}, 32'd0);
    start_fetch("s5_top", 32'hFFFF_FFFC);
    ack_deliver(32'h4444_FFFC, 32'hFFFF_FFFC);
    start_fetch("s5_wrap", 32'h0);
    ack_deliver(32'h5555_0000, 32'h0);

    // Asynchronous reset in the middle of WAIT
    start_fetch("s6_pre", 32'h4);
    tick();
    #2 Reset = 1'b0;
    #1;
    check("s6_rst_memreq", {31'd0, MemReq}, 32'd0);
    check("s6_rst_busy", {31'd0, Busy}, 32'd0);
    check("s6_rst_irwre", {31'd0, IRWre}, 32'd0);
    @(posedge clk);
    #1 Reset = 1'b1;
    start_fetch("s6_post", 32'h0);
    ack_deliver(32'h6666_0000, 32'h0);
    tick();

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
